reg_ce_feeder: RTL and testbench
================================

REG_CE_FEEDER -- requirements
Module: reg_ce_feeder

Interface
REQ-001 Parameter WIDTH, default 16: data width of In0/Out0.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, >= 2.
REQ-003 Parameter PERIOD, default 4: minimum clock edges between CE pulses; >= 1.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 ASYNCRESET  input  1  asynchronous, active-high reset.
REQ-006 In0  input  WIDTH  upstream data word.
REQ-007 InValid  input  1  In0 holds a valid word.
REQ-008 InReady  output  1  block accepts a word this cycle.
REQ-009 Out0  output  WIDTH  registered data for the downstream CE register's data input.
REQ-010 CE  output  1  registered one-cycle load pulse for the downstream CE register's enable input.

Function
REQ-011 Push occurs at an edge where InValid=1 and InReady=1; In0 is written at the FIFO tail.
REQ-012 InReady SHALL be 1 iff occupancy < DEPTH and ASYNCRESET=0; it does not depend on a same-cycle pop.
REQ-013 A 0..PERIOD-1 down-timer gates issue; issue occurs at an edge where occupancy > 0 and timer = 0.
REQ-014 On issue: CE<=1, Out0<=FIFO head, head popped, timer<=PERIOD-1.
REQ-015 On non-issue: CE<=0, Out0 holds; timer decrements if nonzero, else stays 0.
REQ-016 Push and pop at the same edge leave occupancy unchanged; both pointers advance and wrap modulo DEPTH.
REQ-017 The issue decision uses pre-edge occupancy; a word pushed at edge k is issued no earlier than edge k+1 (CE high in the following cycle), so the downstream register loads it at edge k+2 at the earliest.
REQ-018 With PERIOD=1, CE SHALL be high on consecutive cycles while the FIFO is non-empty.
REQ-019 Words SHALL be issued in acceptance order, with no loss or duplication.
REQ-020 CE SHALL never be high for more than one cycle per issued word.
REQ-021 When full, InValid is ignored and no state changes from the input side.

Reset
REQ-022 While ASYNCRESET=1: CE=0, Out0=0, occupancy=0, pointers=0, timer=0, InReady=0, all taking effect immediately and independently of CLK.
REQ-023 Words held in the FIFO at reset assertion SHALL be discarded; no CE pulse for them after release.
REQ-024 On the first edge after release, a push can be accepted; the first issue occurs no earlier than the following edge.

Configuration
REQ-025 Macro REG_CE_FEEDER_COUNT_EN, when defined, SHALL add output IssueCount (16 bits), which counts issues, saturates at 16'hFFFF, and resets to 0 on ASYNCRESET.
REQ-026 Without REG_CE_FEEDER_COUNT_EN, port IssueCount and its counter SHALL not exist; all other behaviour is identical.

Verification (WIDTH=16, DEPTH=4, PERIOD=4 unless stated)
REQ-027 Single word: push 16'hA5A5 at edge 1 -> CE=1, Out0=16'hA5A5 after edge 2 only; CE=0 after edge 3; Out0 stays 16'hA5A5.
REQ-028 Burst/rate: push 16'h0001..16'h0004 on edges 1-4 -> CE pulses after edges 2, 6, 10, 14 carrying 1, 2, 3, 4 in order.
REQ-029 Full: InValid held high with words 1..6 from edge 1 -> InReady drops once occupancy reaches 4; no word is lost; all accepted words are issued in order.
REQ-030 PERIOD=1: push 16'h0010..16'h0013 back-to-back -> CE high for 4 consecutive cycles with data 10, 11, 12, 13.
REQ-031 Reset mid-operation: 3 words queued, ASYNCRESET pulsed between edges -> CE=0, Out0=0 and InReady=0 immediately; after release no stale CE; new word 16'hBEEF issued at edge k+1.
REQ-032 With REG_CE_FEEDER_COUNT_EN defined: 5 issues -> IssueCount=5; a reset clears it to 0.

Source files
------------

// File: rtl/reg_ce_feeder.sv
// ---------------------------------------------------------------------------
// reg_ce_feeder
//
// Purpose:
//   Buffers upstream words in a small FIFO and feeds them to a downstream
//   clock-enabled register. Each issued word shows up on Out0 together with a
//   one-cycle CE pulse. A down-timer keeps consecutive CE pulses at least
//   PERIOD clock edges apart.
//
// Parameters:
//   WIDTH   data width of In0/Out0
//   DEPTH   FIFO entries (power of two, >= 2)
//   PERIOD  minimum clock edges between CE pulses (>= 1)
//
// Ports:
//   CLK         in   single clock, rising edge
//   ASYNCRESET  in   asynchronous active-high reset
//   In0         in   upstream data word
//   InValid     in   In0 holds a valid word
//   InReady     out  word is accepted this cycle (FIFO not full, not in reset)
//   Out0        out  registered data for the downstream register
//   CE          out  registered one-cycle load pulse for the downstream register
//   IssueCount  out  16-bit saturating count of issued words
//                    (present only when REG_CE_FEEDER_COUNT_EN is defined)
//
// Configuration macro:
//   REG_CE_FEEDER_COUNT_EN  adds the IssueCount output and its counter.
// ---------------------------------------------------------------------------
module reg_ce_feeder #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic [WIDTH-1:0] In0,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out0,
  output logic             CE
`ifdef REG_CE_FEEDER_COUNT_EN
  ,
  output logic [15:0]      IssueCount
`endif
);

  // Pointer, occupancy and timer widths. Occupancy needs one extra bit so
  // that "full" (== DEPTH) is distinguishable from "empty".
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(PERIOD - 1);

  // FIFO storage and control state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [TW-1:0]    r_timer;
  logic [WIDTH-1:0] r_out;
  logic             r_ce;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  // Ready looks only at the stored occupancy, never at a same-cycle pop, so
  // there is no combinational path from the issue logic to the upstream side.
  // Reset forces it low immediately, without waiting for a clock edge.
  assign InReady = !ASYNCRESET && (r_count < FULL_COUNT);

  assign w_push  = InValid && InReady;

  // Issue is decided from pre-edge occupancy, so a word written at one edge
  // can be issued at the very next edge but never at the same one.
  assign w_pop   = (r_count != '0) && (r_timer == '0);

  assign w_head  = r_mem[r_rd_ptr];

  // ---- Stage: FIFO write (data storage, not reset) ----
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= In0;
    end
  end

  // ---- Stage: FIFO pointers and occupancy ----
  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- Stage: issue timer and output register ----
  // The timer is reloaded with PERIOD-1 on issue and counts down to zero,
  // which spaces CE pulses exactly PERIOD edges apart under back-pressure.
  // With PERIOD=1 the reload value is zero and CE may stay high each cycle.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_timer <= '0;
      r_ce    <= 1'b0;
      r_out   <= '0;
    end else begin
      if (w_pop) begin
        r_ce    <= 1'b1;
        r_out   <= w_head;
        r_timer <= TIMER_RELOAD;
      end else begin
        r_ce    <= 1'b0;
        if (r_timer != '0) begin
          r_timer <= r_timer - 1'b1;
        end
      end
    end
  end

  assign CE   = r_ce;
  assign Out0 = r_out;

`ifdef REG_CE_FEEDER_COUNT_EN
  // ---- Stage: saturating issue counter ----
  logic [15:0] r_issue_cnt;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      r_issue_cnt <= '0;
    end else if (w_pop && (r_issue_cnt != 16'hFFFF)) begin
      r_issue_cnt <= r_issue_cnt + 16'd1;
    end
  end

  assign IssueCount = r_issue_cnt;
`endif

endmodule

// File: tb/tb_reg_ce_feeder.sv
// ---------------------------------------------------------------------------
// tb_reg_ce_feeder
//
// Drives two instances of reg_ce_feeder from the same stimulus: one with
// PERIOD=4 and one with PERIOD=1 (both WIDTH=16, DEPTH=4). A queue-based
// reference model tracks, per instance, the accepted words and the edge of
// the last issue; a word is issued when the queue is non-empty and at least
// PERIOD edges have passed since the previous issue.
// ---------------------------------------------------------------------------
module tb_reg_ce_feeder;

  localparam int DEPTH = 4;
  localparam int PA    = 4;
  localparam int PB    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In0;
  logic        InValid;

  logic        rdy_a, ce_a, rdy_b, ce_b;
  logic [15:0] out_a, out_b;
`ifdef REG_CE_FEEDER_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  always #5 clk = ~clk;

  reg_ce_feeder #(.WIDTH(16), .DEPTH(DEPTH), .PERIOD(PA)) u_dut_a (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .In0        (In0),
    .InValid    (InValid),
    .InReady    (rdy_a),
    .Out0       (out_a),
    .CE         (ce_a)
`ifdef REG_CE_FEEDER_COUNT_EN
    ,
    .IssueCount (cnt_a)
`endif
  );

  reg_ce_feeder #(.WIDTH(16), .DEPTH(DEPTH), .PERIOD(PB)) u_dut_b (
    .CLK        (clk),
    .ASYNCRESET (rst),
    .In0        (In0),
    .InValid    (InValid),
    .InReady    (rdy_b),
    .Out0       (out_b),
    .CE         (ce_b)
`ifdef REG_CE_FEEDER_COUNT_EN
    ,
    .IssueCount (cnt_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int          last_a, last_b;
  int          edge_n;
  logic        ece_a, ece_b;
  logic [15:0] eout_a, eout_b;
  int          ecnt_a, ecnt_b;

  task automatic model_reset();
    qa.delete();
    qb.delete();
    last_a = -1000;
    last_b = -1000;
    ece_a  = 1'b0;
    ece_b  = 1'b0;
    eout_a = 16'h0;
    eout_b = 16'h0;
    ecnt_a = 0;
    ecnt_b = 0;
  endtask

  task automatic check_outputs(input string where);
    check_val($sformatf("ce_a@%s", where),   32'(ce_a),  32'(ece_a));
    check_val($sformatf("out_a@%s", where),  32'(out_a), 32'(eout_a));
    check_val($sformatf("ce_b@%s", where),   32'(ce_b),  32'(ece_b));
    check_val($sformatf("out_b@%s", where),  32'(out_b), 32'(eout_b));
`ifdef REG_CE_FEEDER_COUNT_EN
    check_val($sformatf("cnt_a@%s", where),  32'(cnt_a), 32'(ecnt_a));
    check_val($sformatf("cnt_b@%s", where),  32'(cnt_b), 32'(ecnt_b));
`endif
  endtask

  // One clock cycle: called at a falling edge, drives inputs, checks the
  // ready outputs before the rising edge, advances the model at the edge and
  // checks the registered outputs just after it.
  task automatic step(input logic v, input logic [15:0] d, output logic acc_a);
    logic pa, pb;
    InValid = v;
    In0     = d;
    #1;
    check_val($sformatf("ready_a@e%0d", edge_n + 1), 32'(rdy_a), 32'(qa.size() < DEPTH));
    check_val($sformatf("ready_b@e%0d", edge_n + 1), 32'(rdy_b), 32'(qb.size() < DEPTH));
    pa    = v && (qa.size() < DEPTH);
    pb    = v && (qb.size() < DEPTH);
    acc_a = pa;
    @(posedge clk);
    edge_n++;
    if ((qa.size() > 0) && (edge_n - last_a >= PA)) begin
      ece_a  = 1'b1;
      eout_a = qa.pop_front();
      last_a = edge_n;
      if (ecnt_a < 65535) ecnt_a++;
    end else begin
      ece_a = 1'b0;
    end
    if ((qb.size() > 0) && (edge_n - last_b >= PB)) begin
      ece_b  = 1'b1;
      eout_b = qb.pop_front();
      last_b = edge_n;
      if (ecnt_b < 65535) ecnt_b++;
    end else begin
      ece_b = 1'b0;
    end
    if (pa) qa.push_back(d);
    if (pb) qb.push_back(d);
    #1;
    check_outputs($sformatf("e%0d", edge_n));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, acc);
  endtask

  // Asynchronous reset pulse starting between edges: outputs must clear
  // immediately, and stay clear across the edge seen while in reset.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_val("rst_ce_a",    32'(ce_a),  32'd0);
    check_val("rst_out_a",   32'(out_a), 32'd0);
    check_val("rst_ready_a", 32'(rdy_a), 32'd0);
    check_val("rst_ce_b",    32'(ce_b),  32'd0);
    check_val("rst_out_b",   32'(out_b), 32'd0);
    check_val("rst_ready_b", 32'(rdy_b), 32'd0);
`ifdef REG_CE_FEEDER_COUNT_EN
    check_val("rst_cnt_a",   32'(cnt_a), 32'd0);
    check_val("rst_cnt_b",   32'(cnt_b), 32'd0);
`endif
    @(posedge clk);
    #1;
    check_val("rst_hold_ce_a", 32'(ce_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic acc;
    logic saw_full;
    int   w, n, dens;

    rst     = 1'b1;
    InValid = 1'b0;
    In0     = 16'h0;
    edge_n  = 0;
    model_reset();

    #2;
    check_val("init_ce_a",    32'(ce_a),  32'd0);
    check_val("init_out_a",   32'(out_a), 32'd0);
    check_val("init_ready_a", 32'(rdy_a), 32'd0);
    check_val("init_ce_b",    32'(ce_b),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single word
    step(1'b1, 16'hA5A5, acc);
    idle(6);

    // Burst of four words, paced by PERIOD on instance A
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), acc);
    idle(16);

    // Fill to full: hold each word until instance A accepts it
    w        = 1;
    n        = 0;
    saw_full = 1'b0;
    while (w <= 6 && n < 200) begin
      step(1'b1, 16'(w), acc);
      if (acc) w++;
      else saw_full = 1'b1;
      n++;
    end
    check_val("full_all_accepted", 32'(w), 32'd7);
    check_val("full_ready_dropped", 32'(saw_full), 32'd1);
    idle(30);

    // Back-to-back words, exercised mainly on the PERIOD=1 instance
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0010 + 16'(i), acc);
    idle(20);

    // Reset with words queued and outputs non-zero, then a fresh word
    step(1'b1, 16'h1111, acc);
    step(1'b1, 16'h2222, acc);
    step(1'b1, 16'h3333, acc);
    pulse_reset();
    step(1'b1, 16'hBEEF, acc);
    idle(8);

    // Randomized traffic with varying density and occasional resets
    dens = 50;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) dens = int'($urandom_range(10, 95));
      if ($urandom_range(0, 79) == 0) pulse_reset();
      step(($urandom_range(0, 99) < dens), 16'($urandom), acc);
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
